// File: rtl/b13_serial_pkg.sv
// -----------------------------------------------------------------------------
// b13_serial_pkg
// Shared definitions for the b13 serial link: the transmitter bit delay, the
// derived slot spacing, the frame size and the receiver state encoding.
// Optional build macro used by the receiver: B13_SERIAL_RX_SYNC_EN.
// -----------------------------------------------------------------------------
package b13_serial_pkg;

   // Transmitter wait between bit slots; receiver slot spacing is this plus 2.
   localparam int DELAY_TIME          = 104;
   localparam int BIT_PERIOD_DEFAULT  = DELAY_TIME + 2;
   localparam int FRAME_DATA_BITS     = 8;

   typedef enum logic [1:0] {
      R_IDLE = 2'b00,
      R_DATA = 2'b01,
      R_STOP = 2'b10
   } rx_state_t;

   // Shift one received bit into the byte, MSB first.
   function automatic logic [7:0] shift_in(input logic [7:0] sh, input logic b);
      return {sh[6:0], b};
   endfunction

endpackage

// File: rtl/b13_serial_rx_sync.sv
// -----------------------------------------------------------------------------
// b13_serial_rx_sync
// Two-flop synchroniser for the serial line. Both flops reset to 1 (idle line
// level) so that reset never looks like a start bit.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous, active-high reset
//   d      - raw serial line
//   q      - synchronised serial line (2 cycles later)
// Only instantiated when B13_SERIAL_RX_SYNC_EN is defined.
// -----------------------------------------------------------------------------
module b13_serial_rx_sync (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_r;

   // Two-stage synchroniser chain, idle-high on reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta_r <= 1'b1;
         q      <= 1'b1;
      end else begin
         meta_r <= d;
         q      <= meta_r;
      end
   end

endmodule

// File: rtl/b13_serial_rx.sv
// -----------------------------------------------------------------------------
// b13_serial_rx
// Receiver for the b13 serial transmitter line. The transmitter idles high and
// drives each bit for a single clock, with slots BIT_PERIOD clocks apart:
// start (0), 8 data bits MSB first, stop (1). The receiver aligns on the start
// slot, samples every following slot, checks framing and offers the byte over
// a valid/ready handshake.
// Ports:
//   clock       - rising-edge clock (same as transmitter)
//   reset       - asynchronous, active-high reset
//   serial_in   - transmitter data_out
//   rx_ready    - consumer accepts rx_data this cycle
//   rx_valid    - rx_data holds an unconsumed byte
//   rx_data     - received byte, bit7 = first data bit
//   frame_error - 1-cycle pulse: bad stop bit or a 0 outside a slot
//   overrun     - 1-cycle pulse: completed byte dropped, holding reg full
//   busy        - a frame is in progress
// Build option: define B13_SERIAL_RX_SYNC_EN to pass serial_in through a
// 2-flop synchroniser (all outputs 2 cycles later, same slot spacing).
// -----------------------------------------------------------------------------
module b13_serial_rx
   import b13_serial_pkg::*;
#(
   parameter int BIT_PERIOD = BIT_PERIOD_DEFAULT,
   parameter int CNT_W      = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       serial_in,
   input  logic       rx_ready,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       frame_error,
   output logic       overrun,
   output logic       busy
);

   rx_state_t        state_r;
   logic [CNT_W-1:0] slot_cnt_r;
   logic [2:0]       bit_idx_r;
   logic [7:0]       shift_r;

   logic line_s;
   logic slot_hit_s;
   logic last_bit_s;
   logic complete_s;

`ifdef B13_SERIAL_RX_SYNC_EN
   b13_serial_rx_sync u_sync (
      .clock (clock),
      .reset (reset),
      .d     (serial_in),
      .q     (line_s)
   );
`else
   assign line_s = serial_in;
`endif

   // Slot timing and frame-complete decode.
   always_comb begin
      slot_hit_s = (slot_cnt_r == CNT_W'(BIT_PERIOD - 1));
      last_bit_s = (bit_idx_r == 3'(FRAME_DATA_BITS - 1));
      if ((state_r == R_STOP) && slot_hit_s && line_s) begin
         complete_s = 1'b1;
      end else begin
         complete_s = 1'b0;
      end
   end

   // Frame FSM, byte assembly and output handshake.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= R_IDLE;
         slot_cnt_r  <= '0;
         bit_idx_r   <= 3'd0;
         shift_r     <= 8'h00;
         rx_valid    <= 1'b0;
         rx_data     <= 8'h00;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         frame_error <= 1'b0;
         overrun     <= 1'b0;

         case (state_r)
            R_IDLE: begin
               if (!line_s) begin
                  state_r    <= R_DATA;
                  slot_cnt_r <= '0;
                  bit_idx_r  <= 3'd0;
                  busy       <= 1'b1;
               end else begin
                  busy       <= 1'b0;
               end
            end
            R_DATA: begin
               if (slot_hit_s) begin
                  shift_r    <= shift_in(shift_r, line_s);
                  slot_cnt_r <= '0;
                  bit_idx_r  <= bit_idx_r + 3'd1;
                  if (last_bit_s) begin
                     state_r <= R_STOP;
                  end else begin
                     state_r <= R_DATA;
                  end
               end else if (!line_s) begin
                  // A 0 between slots means we are misaligned: drop the frame.
                  state_r     <= R_IDLE;
                  slot_cnt_r  <= '0;
                  busy        <= 1'b0;
                  frame_error <= 1'b1;
               end else begin
                  slot_cnt_r  <= slot_cnt_r + CNT_W'(1);
               end
            end
            R_STOP: begin
               if (slot_hit_s) begin
                  state_r     <= R_IDLE;
                  slot_cnt_r  <= '0;
                  busy        <= 1'b0;
                  frame_error <= ~line_s;
               end else if (!line_s) begin
                  state_r     <= R_IDLE;
                  slot_cnt_r  <= '0;
                  busy        <= 1'b0;
                  frame_error <= 1'b1;
               end else begin
                  slot_cnt_r  <= slot_cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_r    <= R_IDLE;
               slot_cnt_r <= '0;
               busy       <= 1'b0;
            end
         endcase

         // A completing byte takes priority; it may replace a byte being
         // consumed in the same cycle, otherwise it is dropped as overrun.
         if (complete_s) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift_r;
               rx_valid <= 1'b1;
            end else begin
               overrun  <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end else begin
            rx_valid <= rx_valid;
         end
      end
   end

endmodule

// File: tb/tb_b13_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_b13_serial_rx
// Scoreboard bench for b13_serial_rx: each stimulus frame pushes the expected
// output event (valid byte, frame error or overrun, with its arrival cycle)
// into a queue; a negedge monitor pops and compares whenever the DUT raises
// rx_valid, frame_error or overrun.
// -----------------------------------------------------------------------------
module tb_b13_serial_rx;

   localparam int BP   = 106;
   localparam int FLEN = 9 * BP;   // start slot to stop slot distance
`ifdef B13_SERIAL_RX_SYNC_EN
   localparam int LAT  = 2;
`else
   localparam int LAT  = 0;
`endif

   localparam int K_VALID = 0;
   localparam int K_FERR  = 1;
   localparam int K_OVR   = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         at;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       serial_in;
   logic       rx_ready;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       frame_error;
   logic       overrun;
   logic       busy;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   logic prev_valid = 1'b0;

   b13_serial_rx dut (
      .clock       (clock),
      .reset       (reset),
      .serial_in   (serial_in),
      .rx_ready    (rx_ready),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .frame_error (frame_error),
      .overrun     (overrun),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_event(input int k);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", k, cyc);
      end else begin
         e = sb.pop_front();
         chk("event_kind", 32'(k), 32'(e.kind));
         chk("event_cycle", 32'(cyc), 32'(e.at));
         if (k != K_FERR) begin
            chk("event_data", 32'(rx_data), 32'(e.data));
         end
      end
   endtask

   // Monitor: compare every DUT output event against the scoreboard.
   always @(negedge clock) begin
      if (!reset) begin
         if (rx_valid && !prev_valid) check_event(K_VALID);
         if (frame_error)             check_event(K_FERR);
         if (overrun)                 check_event(K_OVR);
      end
      prev_valid = rx_valid;
   end

   task automatic push(input int k, input logic [7:0] d, input int at);
      exp_t e;
      e.kind = k;
      e.data = d;
      e.at   = at;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   // Drive one frame as the transmitter would; optionally inject an off-slot
   // zero at offset off_at or assert reset at the start of slot rst_slot.
   task automatic send(input logic [7:0] b, input logic stop, input int off_at, input int rst_slot);
      int slot;
      for (int i = 0; i <= FLEN; i++) begin
         if (rst_slot >= 0 && i == rst_slot * BP) begin
            reset     = 1'b1;
            serial_in = 1'b1;
            return;
         end
         if (off_at >= 0 && i == off_at) begin
            serial_in = 1'b0;
            @(negedge clock);
            serial_in = 1'b1;
            return;
         end
         if (i % BP == 0) begin
            slot = i / BP;
            if (slot == 0)      serial_in = 1'b0;
            else if (slot == 9) serial_in = stop;
            else                serial_in = b[8 - slot];
         end else begin
            serial_in = 1'b1;
         end
         @(negedge clock);
      end
      serial_in = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rx_valid"},    32'(rx_valid),    32'd0);
      chk({tag, "_rx_data"},     32'(rx_data),     32'd0);
      chk({tag, "_frame_error"}, 32'(frame_error), 32'd0);
      chk({tag, "_overrun"},     32'(overrun),     32'd0);
      chk({tag, "_busy"},        32'(busy),        32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      serial_in = 1'b1;
      rx_ready  = 1'b1;
      idle(3);
      check_reset_outputs("reset");
      reset = 1'b0;
      idle(5);

      // 0xA5 with rx_ready held: one-cycle valid pulse.
      push(K_VALID, 8'hA5, cyc + FLEN + 1 + LAT);
      send(8'hA5, 1'b1, -1, -1);
      idle(5 + LAT);
      chk("a5_valid_dropped", 32'(rx_valid), 32'd0);
      chk("a5_data_held",     32'(rx_data),  32'hA5);

      // 0x3C with a bad stop bit.
      push(K_FERR, 8'h00, cyc + FLEN + 1 + LAT);
      send(8'h3C, 1'b0, -1, -1);
      idle(3 + LAT);
      chk("stop_err_busy",  32'(busy),     32'd0);
      chk("stop_err_valid", 32'(rx_valid), 32'd0);

      // 0xFF aborted by an off-slot zero, then a clean 0x81.
      push(K_FERR, 8'h00, cyc + 51 + LAT);
      send(8'hFF, 1'b1, 50, -1);
      idle(3 + LAT);
      chk("offslot_busy", 32'(busy), 32'd0);
      push(K_VALID, 8'h81, cyc + FLEN + 1 + LAT);
      send(8'h81, 1'b1, -1, -1);
      idle(5 + LAT);

      // Back-to-back 0x11, 0x22 with no consumer: overrun on the second.
      rx_ready = 1'b0;
      push(K_VALID, 8'h11, cyc + FLEN + 1 + LAT);
      push(K_OVR,   8'h11, cyc + 2 * (FLEN + 1) + LAT);
      send(8'h11, 1'b1, -1, -1);
      send(8'h22, 1'b1, -1, -1);
      idle(2 + LAT);
      chk("ovr_valid_held", 32'(rx_valid), 32'd1);
      chk("ovr_data_kept",  32'(rx_data),  32'h11);
      rx_ready = 1'b1;
      idle(1);
      chk("ovr_consumed_valid", 32'(rx_valid), 32'd0);
      chk("ovr_consumed_data",  32'(rx_data),  32'h11);
      idle(3);

      // Reset in the middle of 0x5A (at data bit 4), then resend.
      send(8'h5A, 1'b1, -1, 5);
      idle(2);
      check_reset_outputs("midreset");
      reset = 1'b0;
      idle(3 + LAT);
      chk("midreset_busy_after", 32'(busy), 32'd0);
      push(K_VALID, 8'h5A, cyc + FLEN + 1 + LAT);
      send(8'h5A, 1'b1, -1, -1);
      idle(10 + LAT);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
